// File: rtl/alu_if.sv
// Operand/result handshake bundle between the operand muxes, the ALU and the writeback mux.
// The slave modport is the ALU side; the master modport is the control/datapath side.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [2:0]       SELECT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] RESULT;
  logic             ZERO;
  logic             BUSY;

  modport master (
    output IN_VALID, DATA1, DATA2, SELECT, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, ZERO, BUSY
  );

  modport slave (
    input  IN_VALID, DATA1, DATA2, SELECT, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, ZERO, BUSY
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU: single-cycle FWD/ADD/AND/OR/JMP, bit-serial SLL/SRA and
// shift-add MUL, all launched and retired through a valid/ready handshake.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic CLK,
  input  logic RESET,
  alu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_FWD = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_JMP = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  localparam logic [SHAMT_W:0] CNT_ONE = (SHAMT_W + 1)'(1);
  localparam logic [SHAMT_W:0] CNT_MUL = (SHAMT_W + 1)'(WIDTH);

  generate
    if (WIDTH < 8 || SHAMT_W != $clog2(WIDTH)) begin : g_param_chk
      $error("alu_multicycle: WIDTH must be >= 8 and SHAMT_W must equal clog2(WIDTH)");
    end
  endgenerate

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [SHAMT_W:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  op_e              sel_in;
  logic [SHAMT_W-1:0] sh_in;
  logic             multi_in;
  logic [WIDTH-1:0] imm_in;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mcand_d;
  logic [WIDTH-1:0] mplier_d;
  logic [SHAMT_W:0] cnt_d;
  logic             last_d;
  logic signed [WIDTH-1:0] acc_s;

  // Result of every op that can retire on the accept edge; shifts only get here with sh=0.
  function automatic logic [WIDTH-1:0] imm_result(input op_e op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:         r = a + b;
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_SLL, OP_SRA: r = a;
      default:        r = b;
    endcase
    return r;
  endfunction

  assign sel_in   = op_e'(bus.SELECT);
  assign sh_in    = bus.DATA2[SHAMT_W-1:0];
  assign multi_in = (sel_in == OP_MUL) ||
                    (((sel_in == OP_SLL) || (sel_in == OP_SRA)) && (sh_in != '0));
  assign imm_in   = imm_result(sel_in, bus.DATA1, bus.DATA2);
  assign acc_s    = acc_q;

  // One iteration of the serial engine; last_d flags the edge that retires the op.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q - CNT_ONE;
    last_d   = 1'b0;
    case (op_q)
      OP_SLL: begin
        acc_d  = acc_q << 1;
        last_d = (cnt_d == '0);
      end
      OP_SRA: begin
        acc_d  = acc_s >>> 1;
        last_d = (cnt_d == '0);
      end
      OP_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        last_d   = (cnt_d == '0) || (mplier_d == '0);
      end
      default: last_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      op_q        <= OP_FWD;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.IN_VALID && in_ready_q) begin
            op_q       <= sel_in;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (multi_in) begin
              state_q <= S_EXEC;
              if (sel_in == OP_MUL) begin
                acc_q    <= '0;
                mcand_q  <= bus.DATA1;
                mplier_q <= bus.DATA2;
                cnt_q    <= CNT_MUL;
              end else begin
                acc_q <= bus.DATA1;
                cnt_q <= {1'b0, sh_in};
              end
            end else begin
              state_q     <= S_DONE;
              result_q    <= imm_in;
              zero_q      <= ~|imm_in;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (last_d) begin
            state_q     <= S_DONE;
            result_q    <= acc_d;
            zero_q      <= ~|acc_d;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          // IN_READY stays low here so a new op can never overlap the retiring one.
          if (bus.OUT_READY) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.RESULT    = result_q;
  assign bus.ZERO      = zero_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 32-bit instance driven from a hand-computed vector
// table plus handshake/reset scenarios, and an 8-bit instance swept against a small model.
module tb_alu_multicycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(32)) b32 ();
  alu_if #(.WIDTH(8))  b8 ();

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut32 (.CLK(clk), .RESET(rst), .bus(b32.slave));
  alu_multicycle #(.WIDTH(8),  .SHAMT_W(3)) dut8  (.CLK(clk), .RESET(rst), .bus(b8.slave));

  int checks   = 0;
  int failures = 0;

  bit          nar = 1'b0;
  logic [31:0] o_res;
  logic        o_vld, o_rdy, o_zero, o_busy;
  assign o_res  = nar ? {24'h0, b8.RESULT} : b32.RESULT;
  assign o_vld  = nar ? b8.OUT_VALID : b32.OUT_VALID;
  assign o_rdy  = nar ? b8.IN_READY  : b32.IN_READY;
  assign o_zero = nar ? b8.ZERO      : b32.ZERO;
  assign o_busy = nar ? b8.BUSY      : b32.BUSY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic v);
    if (nar) begin
      b8.SELECT = op; b8.DATA1 = a[7:0]; b8.DATA2 = b[7:0]; b8.IN_VALID = v;
    end else begin
      b32.SELECT = op; b32.DATA1 = a; b32.DATA2 = b; b32.IN_VALID = v;
    end
  endtask

  task automatic set_ordy(input logic v);
    if (nar) b8.OUT_READY = v;
    else     b32.OUT_READY = v;
  endtask

  // Launch one op, measure latency from the accept edge, hold it in DONE for 'stall' cycles,
  // then retire it and confirm the return to IDLE.
  task automatic run_op(input string tag, input bit n, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int exp_lat, input int stall);
    int lat;
    nar = n;
    set_ordy(1'b0);
    @(negedge clk);
    chk({tag, "/in_ready"}, 32'(o_rdy), 32'd1);
    drive(op, a, b, 1'b1);
    @(posedge clk);
    #1 drive(~op, ~a, ~b, 1'b0);
    lat = 1;
    @(negedge clk);
    while (!o_vld && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, o_res, exp);
    chk({tag, "/zero"}, 32'(o_zero), 32'(exp == 32'h0));
    chk({tag, "/busy"}, 32'(o_busy), 32'd1);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk({tag, "/stall_hold"}, {o_res[30:0], o_vld}, {exp[30:0], 1'b1});
    end
    set_ordy(1'b1);
    @(negedge clk);
    chk({tag, "/retire"}, {29'h0, o_vld, o_rdy, o_busy}, 32'b010);
    set_ordy(1'b0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs [18] = '{
    '{3'b000, 32'h0000_1234, 32'hCAFE_BABE, 32'hCAFE_BABE,  1},
    '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,  1},
    '{3'b001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000,  1},
    '{3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0,  1},
    '{3'b011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F,  1},
    '{3'b100, 32'h0000_0001, 32'h0040_0000, 32'h0040_0000,  1},
    '{3'b110, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000,  5},
    '{3'b101, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678,  1},
    '{3'b101, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006,  2},
    '{3'b101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32},
    '{3'b110, 32'h8000_0001, 32'h0000_001F, 32'hFFFF_FFFF, 32},
    '{3'b110, 32'h4000_0000, 32'h0000_001F, 32'h0000_0000, 32},
    '{3'b110, 32'h7FFF_FFF0, 32'h0000_0024, 32'h07FF_FFFF,  5},
    '{3'b111, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F,  4},
    '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33},
    '{3'b111, 32'h0000_1234, 32'h0000_0001, 32'h0000_1234,  2},
    '{3'b111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000,  2},
    '{3'b111, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 18}
  };

  function automatic logic [7:0] model8(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic signed [7:0] s;
    logic [15:0]       p;
    s = a;
    p = 16'(a) * 16'(b);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return a << b[2:0];
      3'b110:  return s >>> b[2:0];
      3'b111:  return p[7:0];
      default: return b;
    endcase
  endfunction

  function automatic int lat8(input logic [2:0] op, input logic [7:0] b);
    int n;
    if (op == 3'b101 || op == 3'b110) return (b[2:0] == 3'd0) ? 1 : int'(b[2:0]) + 1;
    if (op == 3'b111) begin
      n = 1;
      for (int k = 0; k < 8; k++) if (b[k]) n = k + 1;
      return n + 1;
    end
    return 1;
  endfunction

  logic [2:0] r_op;
  logic [7:0] r_a, r_b;

  initial begin
    nar = 1'b0; drive(3'b000, 32'h0, 32'h0, 1'b0); b32.OUT_READY = 1'b0;
    nar = 1'b1; drive(3'b000, 32'h0, 32'h0, 1'b0); b8.OUT_READY  = 1'b0;
    nar = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/state", {27'h0, o_rdy, o_vld, o_busy, o_zero, 1'b0}, 32'b10010);
    chk("reset/result", o_res, 32'h0);
    chk("reset/result8", {24'h0, b8.RESULT}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
             vecs[i].lat, i % 3);

    // DONE held under backpressure; IN_VALID pulses in DONE must not be taken.
    nar = 1'b0;
    @(negedge clk);
    drive(3'b001, 32'd2, 32'd2, 1'b1);
    @(posedge clk);
    #1 drive(3'b011, 32'hFF, 32'h0, 1'b0);
    @(negedge clk);
    chk("bp/first", {o_res[30:0], o_vld}, {31'd4, 1'b1});
    for (int i = 0; i < 10; i++) begin
      drive(3'b001, 32'd100, 32'(i), i[0]);
      @(negedge clk);
      chk($sformatf("bp/hold%0d", i), {27'h0, o_res[1:0], o_vld, o_rdy, o_busy},
          {27'h0, 2'b00, 1'b1, 1'b0, 1'b1});
      chk($sformatf("bp/res%0d", i), o_res, 32'd4);
    end
    drive(3'b011, 32'hA0, 32'h05, 1'b1);
    b32.OUT_READY = 1'b1;
    @(negedge clk);
    chk("bp/release", {29'h0, o_vld, o_rdy, o_busy}, 32'b010);
    chk("bp/release_res", o_res, 32'd4);
    b32.OUT_READY = 1'b0;
    @(posedge clk);
    #1 b32.IN_VALID = 1'b0;
    @(negedge clk);
    chk("bp/next_vld", 32'(o_vld), 32'd1);
    chk("bp/next_res", o_res, 32'hA5);
    b32.OUT_READY = 1'b1;
    @(negedge clk);
    b32.OUT_READY = 1'b0;

    // Asynchronous abort in the middle of a long multiply.
    @(negedge clk);
    drive(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk);
    #1 b32.IN_VALID = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mul/result", o_res, 32'h0);
    chk("rst_mul/ctrl", {28'h0, o_rdy, o_vld, o_busy, o_zero}, 32'b1001);
    @(negedge clk);
    rst = 1'b0;
    run_op("rst_add", 1'b0, 3'b001, 32'd2, 32'd3, 32'd5, 1, 0);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = 8'($urandom);
      r_b  = 8'($urandom);
      if (i < 8) r_op = 3'(i);
      run_op($sformatf("w8_%0d_op%0d", i, r_op), 1'b1, r_op, 32'(r_a), 32'(r_b),
             32'(model8(r_op, r_a, r_b)), lat8(r_op, r_b), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
